// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder.
// Legality check and stage-count math for WIDTH/SEG splits.
package cla_pkg;

   localparam int GRP = 4;

   function automatic bit seg_ok(input int w, input int s);
      return (s > 0) && (w >= s) && (w % s == 0) && (s % GRP == 0);
   endfunction

   function automatic int nstg(input int w, input int s);
      return w / s;
   endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG-bit lookahead segment: 4-bit G/P groups
// plus a second lookahead level across the groups.
module cla_seg
   import cla_pkg::*;
#(
   parameter int SEG = 16
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout,
   output logic           cmsb
);

   localparam int NG = SEG / GRP;

   logic [SEG-1:0] p;
   logic [SEG-1:0] g;
   logic [SEG-1:0] c;
   logic [NG-1:0]  gp;
   logic [NG-1:0]  gg;
   logic [NG:0]    gc;

   assign p = a ^ b;
   assign g = a & b;

   // group propagate / generate for each nibble
   always_comb begin
      gp = '0;
      gg = '0;
      for (int j = 0; j < NG; j++) begin
         gp[j] = &p[j*GRP +: GRP];
         gg[j] = g[j*GRP+3]
               | (p[j*GRP+3] & g[j*GRP+2])
               | (p[j*GRP+3] & p[j*GRP+2] & g[j*GRP+1])
               | (p[j*GRP+3] & p[j*GRP+2] & p[j*GRP+1]
                  & g[j*GRP]);
      end
   end

   // second level: each group carry as a flat sum of products
   always_comb begin
      logic t;
      t  = 1'b0;
      gc = '0;
      for (int j = 0; j <= NG; j++) begin
         t = cin;
         for (int m = 0; m < j; m++) t = t & gp[m];
         gc[j] = t;
         for (int i = 0; i < j; i++) begin
            t = gg[i];
            for (int m = i + 1; m < j; m++) t = t & gp[m];
            gc[j] = gc[j] | t;
         end
      end
   end

   // bit carries inside each group from the group carry-in
   always_comb begin
      c = '0;
      for (int j = 0; j < NG; j++) begin
         c[j*GRP]   = gc[j];
         c[j*GRP+1] = g[j*GRP] | (p[j*GRP] & gc[j]);
         c[j*GRP+2] = g[j*GRP+1]
                    | (p[j*GRP+1] & g[j*GRP])
                    | (p[j*GRP+1] & p[j*GRP] & gc[j]);
         c[j*GRP+3] = g[j*GRP+2]
                    | (p[j*GRP+2] & g[j*GRP+1])
                    | (p[j*GRP+2] & p[j*GRP+1] & g[j*GRP])
                    | (p[j*GRP+2] & p[j*GRP+1] & p[j*GRP]
                       & gc[j]);
      end
   end

   assign sum  = p ^ c;
   assign cout = gc[NG];
   assign cmsb = c[SEG-1];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead add/sub, one SEG-bit segment per stage.
// Stage regs carry done sum segments, pending operands and the carry.
module cla_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SEG   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int NSTG = nstg(WIDTH, SEG);

   if (!seg_ok(WIDTH, SEG)) begin : g_bad
      $error("cla_pipe: illegal WIDTH/SEG combination");
   end

   logic             adv;
   logic [WIDTH-1:0] b_in;

   logic             vld_q [NSTG];
   logic             vld_d [NSTG];
   logic [WIDTH-1:0] acc_q [NSTG];
   logic [WIDTH-1:0] acc_d [NSTG];
   logic [WIDTH-1:0] b_q   [NSTG];
   logic [WIDTH-1:0] b_d   [NSTG];
   logic             c_q   [NSTG];
   logic             c_d   [NSTG];
   logic             cmsb_q;
   logic             cmsb_d;

   logic [SEG-1:0]   seg_a  [NSTG];
   logic [SEG-1:0]   seg_b  [NSTG];
   logic [SEG-1:0]   seg_s  [NSTG];
   logic             seg_ci [NSTG];
   logic             seg_co [NSTG];
   logic             seg_cm [NSTG];

   assign b_in     = in_sub ? ~in_b : in_b;
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      if (k == 0) begin : g_first
         assign seg_a[k]  = in_a[SEG-1:0];
         assign seg_b[k]  = b_in[SEG-1:0];
         assign seg_ci[k] = in_sub | in_cin;
      end else begin : g_next
         assign seg_a[k]  = acc_q[k-1][k*SEG +: SEG];
         assign seg_b[k]  = b_q[k-1][k*SEG +: SEG];
         assign seg_ci[k] = c_q[k-1];
      end

      cla_seg #(
         .SEG (SEG)
      ) u_seg (
         .a    (seg_a[k]),
         .b    (seg_b[k]),
         .cin  (seg_ci[k]),
         .sum  (seg_s[k]),
         .cout (seg_co[k]),
         .cmsb (seg_cm[k])
      );
   end

   // next stage contents: shift forward, splice in each new segment
   always_comb begin
      vld_d[0]          = in_valid;
      acc_d[0]          = in_a;
      acc_d[0][SEG-1:0] = seg_s[0];
      b_d[0]            = b_in;
      c_d[0]            = seg_co[0];
      for (int k = 1; k < NSTG; k++) begin
         vld_d[k]                = vld_q[k-1];
         acc_d[k]                = acc_q[k-1];
         acc_d[k][k*SEG +: SEG]  = seg_s[k];
         b_d[k]                  = b_q[k-1];
         c_d[k]                  = seg_co[k];
      end
      cmsb_d = seg_cm[NSTG-1];
   end

   // whole pipe advances together or holds, bubbles included
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTG; k++) begin
            vld_q[k] <= 1'b0;
            acc_q[k] <= '0;
            b_q[k]   <= '0;
            c_q[k]   <= 1'b0;
         end
         cmsb_q <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < NSTG; k++) begin
            vld_q[k] <= vld_d[k];
            acc_q[k] <= acc_d[k];
            b_q[k]   <= b_d[k];
            c_q[k]   <= c_d[k];
         end
         cmsb_q <= cmsb_d;
      end
   end

   assign out_valid = vld_q[NSTG-1];
   assign out_sum   = acc_q[NSTG-1];
   assign out_cout  = c_q[NSTG-1];
   assign out_ovf   = c_q[NSTG-1] ^ cmsb_q;

endmodule
